// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if: control and display bundle of the MM:SS stopwatch core.
// The controller side (master) issues pulses and the preset value; the core
// side (slave) returns the live count, the display value and status flags.
interface stopwatch_core_if;
   logic        start_stop;
   logic        clear;
   logic        load;
   logic [15:0] load_val;
   logic        down;
   logic        lap;
   logic [15:0] bcd;
   logic [15:0] disp;
   logic        running;
   logic        expired;
   logic        wrap;
   logic        lap_active;

   modport master (
      output start_stop, clear, load, load_val, down, lap,
      input  bcd, disp, running, expired, wrap, lap_active
   );

   modport slave (
      input  start_stop, clear, load, load_val, down, lap,
      output bcd, disp, running, expired, wrap, lap_active
   );
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core: synchronous BCD MM:SS stopwatch / count-down timer.
// A prescaler turns TICK_DIV clock cycles into one count step. The count is
// held as four BCD digits {min_tens, min_units, sec_tens, sec_units}.
// Optional feature macro: STOPWATCH_LAP_EN adds the lap-freeze register;
// without it the lap input is ignored and disp simply mirrors bcd.
module stopwatch_core #(
   parameter int TICK_DIV     = 100_000_000,
   parameter int MIN_TENS_MAX = 5
) (
   input logic             clk,
   input logic             r,
   stopwatch_core_if.slave sw
);

   localparam int             PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_EXPIRED
   } state_t;

   state_t         state_reg;
   logic [15:0]    bcd_reg;
   logic [PW-1:0]  pre_reg;
   logic           down_reg;
   logic           running_reg;
   logic           expired_reg;
   logic           wrap_reg;

   // Per-digit next values: saturated preset, incremented and decremented count.
   logic [15:0]    sat_val;
   logic [15:0]    inc_val;
   logic [15:0]    dec_val;
   logic [4:0]     carry;
   logic [4:0]     borrow;

   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         // Digit 1 is sec_tens (0..5), digit 3 is min_tens, the units are 0..9.
         localparam logic [3:0] MAXV = (gi == 1) ? 4'd5 :
                                       (gi == 3) ? 4'(MIN_TENS_MAX) : 4'd9;
         logic [3:0] cur;
         logic [3:0] raw;

         assign cur = bcd_reg[gi*4 +: 4];
         assign raw = sw.load_val[gi*4 +: 4];

         assign sat_val[gi*4 +: 4] = (raw > MAXV) ? MAXV : raw;

         assign inc_val[gi*4 +: 4] = !carry[gi]    ? cur   :
                                     (cur == MAXV) ? 4'd0  : cur + 4'd1;
         assign carry[gi+1]        = carry[gi] & (cur == MAXV);

         assign dec_val[gi*4 +: 4] = !borrow[gi]   ? cur   :
                                     (cur == 4'd0) ? MAXV  : cur - 4'd1;
         assign borrow[gi+1]       = borrow[gi] & (cur == 4'd0);
      end
   endgenerate

`ifdef STOPWATCH_LAP_EN
   logic           lap_active_reg;
   logic [15:0]    lap_val_reg;
`endif

   // Control FSM, prescaler, count and lap register advance together.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state_reg      <= S_IDLE;
         bcd_reg        <= '0;
         pre_reg        <= '0;
         down_reg       <= 1'b0;
         running_reg    <= 1'b0;
         expired_reg    <= 1'b0;
         wrap_reg       <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_active_reg <= 1'b0;
         lap_val_reg    <= '0;
`endif
      end else begin
         wrap_reg <= 1'b0;
         if (sw.clear) begin
            state_reg      <= S_IDLE;
            bcd_reg        <= '0;
            pre_reg        <= '0;
            running_reg    <= 1'b0;
            expired_reg    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_active_reg <= 1'b0;
`endif
         end else if (sw.load && (state_reg != S_RUN)) begin
            // A load while running is dropped and lower commands still apply.
            state_reg   <= S_IDLE;
            bcd_reg     <= sat_val;
            pre_reg     <= '0;
            running_reg <= 1'b0;
            expired_reg <= 1'b0;
         end else if (sw.start_stop && (state_reg != S_EXPIRED)) begin
            if (state_reg == S_RUN) begin
               state_reg   <= S_PAUSE;
               running_reg <= 1'b0;
            end else if (!(sw.down && (bcd_reg == 16'h0000))) begin
               // Direction is latched here and ignored until the next start.
               state_reg   <= S_RUN;
               running_reg <= 1'b1;
               down_reg    <= sw.down;
            end
         end else begin
`ifdef STOPWATCH_LAP_EN
            // Capture uses the pre-step count even when a step lands this edge.
            if (sw.lap && ((state_reg == S_RUN) || (state_reg == S_PAUSE))) begin
               if (!lap_active_reg) begin
                  lap_active_reg <= 1'b1;
                  lap_val_reg    <= bcd_reg;
               end else begin
                  lap_active_reg <= 1'b0;
               end
            end
`endif
            if (state_reg == S_RUN) begin
               if (pre_reg == PRE_LAST) begin
                  pre_reg <= '0;
                  if (down_reg) begin
                     bcd_reg <= dec_val;
                     if (dec_val == 16'h0000) begin
                        state_reg   <= S_EXPIRED;
                        running_reg <= 1'b0;
                        expired_reg <= 1'b1;
                     end
                  end else begin
                     bcd_reg <= inc_val;
                     // Carry out of min_tens means MAX:59 rolled to 00:00.
                     if (carry[4]) begin
                        wrap_reg <= 1'b1;
                     end
                  end
               end else begin
                  pre_reg <= pre_reg + PW'(1);
               end
            end
         end
      end
   end

   assign sw.bcd     = bcd_reg;
   assign sw.running = running_reg;
   assign sw.expired = expired_reg;
   assign sw.wrap    = wrap_reg;

`ifdef STOPWATCH_LAP_EN
   assign sw.disp       = lap_active_reg ? lap_val_reg : bcd_reg;
   assign sw.lap_active = lap_active_reg;

   logic unused_ok;
   assign unused_ok = &{1'b0, borrow[4]};
`else
   assign sw.disp       = bcd_reg;
   assign sw.lap_active = 1'b0;

   logic unused_ok;
   assign unused_ok = &{1'b0, borrow[4], sw.lap};
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed scenarios plus randomized traffic checked
// against a seconds-based reference model of the stopwatch.
`timescale 1ns/1ps
module tb_stopwatch_core;

   localparam int TICK_DIV = 4;
   localparam int MTM      = 5;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif
   localparam int MAXC    = (MTM * 10 + 9) * 60 + 59;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_EXP   = 3;

   logic clk = 1'b0;
   logic r   = 1'b0;

   stopwatch_core_if sw_if ();

   stopwatch_core #(
      .TICK_DIV     (TICK_DIV),
      .MIN_TENS_MAX (MTM)
   ) dut (
      .clk (clk),
      .r   (r),
      .sw  (sw_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: count kept as plain seconds.
   int m_state, m_count, m_phase, m_lap_cnt;
   bit m_down, m_wrap, m_exp, m_lap_on;

   function automatic logic [15:0] to_bcd(int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic int load_secs(logic [15:0] v);
      int d[4];
      for (int i = 0; i < 4; i++) d[i] = int'(v[i*4 +: 4]);
      if (d[0] > 9)   d[0] = 9;
      if (d[1] > 5)   d[1] = 5;
      if (d[2] > 9)   d[2] = 9;
      if (d[3] > MTM) d[3] = MTM;
      return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
   endfunction

   function automatic logic [35:0] exp_vec();
      logic [15:0] b;
      b = to_bcd(m_count);
      return {b, (m_lap_on ? to_bcd(m_lap_cnt) : b), (m_state == M_RUN), m_exp, m_wrap, m_lap_on};
   endfunction

   function automatic logic [35:0] dut_vec();
      return {sw_if.bcd, sw_if.disp, sw_if.running, sw_if.expired, sw_if.wrap, sw_if.lap_active};
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_count = 0; m_phase = 0; m_lap_cnt = 0;
      m_down = 0; m_wrap = 0; m_exp = 0; m_lap_on = 0;
   endtask

   task automatic model_edge(bit ss, bit clr, bit ld, logic [15:0] lv, bit dn, bit lp);
      m_wrap = 0;
      if (clr) begin
         m_count = 0; m_phase = 0; m_lap_on = 0; m_state = M_IDLE; m_exp = 0;
      end else if (ld && m_state != M_RUN) begin
         m_count = load_secs(lv); m_phase = 0; m_state = M_IDLE; m_exp = 0;
      end else if (ss && m_state != M_EXP) begin
         if (m_state == M_RUN) m_state = M_PAUSE;
         else if (!(dn && m_count == 0)) begin
            m_state = M_RUN;
            m_down  = dn;
         end
      end else begin
         if (LAP_EN && lp && (m_state == M_RUN || m_state == M_PAUSE)) begin
            if (!m_lap_on) begin
               m_lap_on  = 1;
               m_lap_cnt = m_count;
            end else m_lap_on = 0;
         end
         if (m_state == M_RUN) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
               m_phase = 0;
               if (m_down) begin
                  m_count--;
                  if (m_count == 0) begin
                     m_state = M_EXP;
                     m_exp   = 1;
                  end
               end else if (m_count == MAXC) begin
                  m_count = 0;
                  m_wrap  = 1;
               end else m_count++;
            end
         end
      end
   endtask

   // One clock: apply inputs, let the DUT and the model take the edge, sample #1 later.
   task automatic drive(bit ss, bit clr, bit ld, logic [15:0] lv, bit dn, bit lp);
      sw_if.start_stop = ss;
      sw_if.clear      = clr;
      sw_if.load       = ld;
      sw_if.load_val   = lv;
      sw_if.down       = dn;
      sw_if.lap        = lp;
      @(posedge clk);
      model_edge(ss, clr, ld, lv, dn, lp);
      #1;
      sw_if.start_stop = 1'b0;
      sw_if.clear      = 1'b0;
      sw_if.load       = 1'b0;
      sw_if.lap        = 1'b0;
   endtask

   task automatic idle(int n, bit dn);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0000, dn, 0);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      total++;
      if (dut_vec() !== 36'h0) begin
         bad++;
         $display("FAIL reset_state got=%h want=%h", dut_vec(), 36'h0);
      end
      r = 1'b1;
      idle(2, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL reset_idle got=%h want=%h", dut_vec(), exp_vec());
      end
      $display("txn reset bcd=%h running=%b", sw_if.bcd, sw_if.running);
   endtask

   task automatic test_count_up();
      drive(0, 1, 0, 16'h0000, 0, 0);
      drive(1, 0, 0, 16'h0000, 0, 0);
      total++;
      if (sw_if.running !== 1'b1) begin
         bad++;
         $display("FAIL up_running got=%b want=1", sw_if.running);
      end
      idle(3, 0);
      total++;
      if (sw_if.bcd !== 16'h0000) begin
         bad++;
         $display("FAIL up_before_step got=%h want=0000", sw_if.bcd);
      end
      idle(1, 0);
      total++;
      if (sw_if.bcd !== 16'h0001) begin
         bad++;
         $display("FAIL up_first_step got=%h want=0001", sw_if.bcd);
      end
      idle(36, 0);
      total++;
      if (sw_if.bcd !== 16'h0010 || sw_if.running !== 1'b1) begin
         bad++;
         $display("FAIL up_ten_steps got=%h/%b want=0010/1", sw_if.bcd, sw_if.running);
      end
      total++;
      if (dut_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL up_model got=%h want=%h", dut_vec(), exp_vec());
      end
      $display("txn count_up bcd=%h", sw_if.bcd);
   endtask

   task automatic test_wrap();
      drive(0, 1, 0, 16'h0000, 0, 0);
      drive(0, 0, 1, 16'h5958, 0, 0);
      drive(1, 0, 0, 16'h0000, 0, 0);
      idle(4, 0);
      total++;
      if (sw_if.bcd !== 16'h5959 || sw_if.wrap !== 1'b0) begin
         bad++;
         $display("FAIL wrap_max got=%h/%b want=5959/0", sw_if.bcd, sw_if.wrap);
      end
      idle(3, 0);
      total++;
      if (sw_if.wrap !== 1'b0) begin
         bad++;
         $display("FAIL wrap_early got=%b want=0", sw_if.wrap);
      end
      idle(1, 0);
      total++;
      if (sw_if.bcd !== 16'h0000 || sw_if.wrap !== 1'b1 || sw_if.running !== 1'b1) begin
         bad++;
         $display("FAIL wrap_pulse got=%h/%b/%b want=0000/1/1", sw_if.bcd, sw_if.wrap, sw_if.running);
      end
      idle(1, 0);
      total++;
      if (sw_if.wrap !== 1'b0) begin
         bad++;
         $display("FAIL wrap_one_cycle got=%b want=0", sw_if.wrap);
      end
      $display("txn wrap bcd=%h", sw_if.bcd);
   endtask

   task automatic test_count_down();
      drive(0, 1, 0, 16'h0000, 1, 0);
      drive(1, 0, 0, 16'h0000, 1, 0);
      total++;
      if (sw_if.running !== 1'b0) begin
         bad++;
         $display("FAIL down_zero_start got=%b want=0", sw_if.running);
      end
      drive(0, 0, 1, 16'h0002, 1, 0);
      drive(1, 0, 0, 16'h0000, 1, 0);
      idle(4, 1);
      total++;
      if (sw_if.bcd !== 16'h0001 || sw_if.expired !== 1'b0) begin
         bad++;
         $display("FAIL down_step got=%h/%b want=0001/0", sw_if.bcd, sw_if.expired);
      end
      idle(4, 0);
      total++;
      if (sw_if.bcd !== 16'h0000 || sw_if.expired !== 1'b1 || sw_if.running !== 1'b0) begin
         bad++;
         $display("FAIL down_expire got=%h/%b/%b want=0000/1/0", sw_if.bcd, sw_if.expired, sw_if.running);
      end
      drive(1, 0, 0, 16'h0000, 0, 0);
      idle(5, 0);
      total++;
      if (sw_if.expired !== 1'b1 || sw_if.running !== 1'b0) begin
         bad++;
         $display("FAIL down_start_ignored got=%b/%b want=1/0", sw_if.expired, sw_if.running);
      end
      drive(0, 1, 0, 16'h0000, 0, 0);
      total++;
      if (sw_if.expired !== 1'b0 || dut_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL down_clear got=%h want=%h", dut_vec(), exp_vec());
      end
      $display("txn count_down expired=%b", sw_if.expired);
   endtask

   task automatic test_pause();
      drive(0, 1, 0, 16'h0000, 0, 0);
      drive(1, 0, 0, 16'h0000, 0, 0);
      idle(2, 0);
      drive(1, 0, 0, 16'h0000, 0, 0);
      idle(10, 0);
      total++;
      if (sw_if.running !== 1'b0 || sw_if.bcd !== 16'h0000) begin
         bad++;
         $display("FAIL pause_hold got=%b/%h want=0/0000", sw_if.running, sw_if.bcd);
      end
      drive(1, 0, 0, 16'h0000, 0, 0);
      drive(0, 0, 1, 16'h1234, 0, 0);
      total++;
      if (sw_if.bcd !== 16'h0000 || sw_if.running !== 1'b1) begin
         bad++;
         $display("FAIL pause_load_ignored got=%h/%b want=0000/1", sw_if.bcd, sw_if.running);
      end
      idle(1, 0);
      total++;
      if (sw_if.bcd !== 16'h0001) begin
         bad++;
         $display("FAIL pause_fraction got=%h want=0001", sw_if.bcd);
      end
      $display("txn pause bcd=%h", sw_if.bcd);
   endtask

   task automatic test_saturation();
      drive(0, 1, 0, 16'h0000, 0, 0);
      drive(0, 0, 1, 16'hAF7C, 0, 0);
      total++;
      if (sw_if.bcd !== 16'h5959) begin
         bad++;
         $display("FAIL saturate got=%h want=5959", sw_if.bcd);
      end
      drive(0, 1, 1, 16'h1234, 0, 0);
      total++;
      if (sw_if.bcd !== 16'h0000) begin
         bad++;
         $display("FAIL clear_beats_load got=%h want=0000", sw_if.bcd);
      end
      $display("txn saturation bcd=%h", sw_if.bcd);
   endtask

   task automatic test_lap();
      logic [15:0] want_disp;
      drive(0, 1, 0, 16'h0000, 0, 0);
      drive(1, 0, 0, 16'h0000, 0, 0);
      idle(12, 0);
      total++;
      if (sw_if.bcd !== 16'h0003) begin
         bad++;
         $display("FAIL lap_setup got=%h want=0003", sw_if.bcd);
      end
      drive(0, 0, 0, 16'h0000, 0, 1);
      idle(7, 0);
      want_disp = LAP_EN ? 16'h0003 : 16'h0005;
      total++;
      if (sw_if.bcd !== 16'h0005 || sw_if.disp !== want_disp || sw_if.lap_active !== LAP_EN) begin
         bad++;
         $display("FAIL lap_freeze got=%h/%h/%b want=0005/%h/%b",
                  sw_if.bcd, sw_if.disp, sw_if.lap_active, want_disp, LAP_EN);
      end
      drive(0, 0, 0, 16'h0000, 0, 1);
      total++;
      if (sw_if.disp !== 16'h0005 || sw_if.lap_active !== 1'b0) begin
         bad++;
         $display("FAIL lap_release got=%h/%b want=0005/0", sw_if.disp, sw_if.lap_active);
      end
      $display("txn lap disp=%h", sw_if.disp);
   endtask

   task automatic test_async_reset();
      drive(0, 1, 0, 16'h0000, 0, 0);
      drive(0, 0, 1, 16'h0307, 0, 0);
      drive(1, 0, 0, 16'h0000, 0, 0);
      idle(6, 0);
      #2;
      r = 1'b0;
      #1;
      model_reset();
      total++;
      if (dut_vec() !== 36'h0) begin
         bad++;
         $display("FAIL async_reset got=%h want=%h", dut_vec(), 36'h0);
      end
      @(posedge clk);
      #1;
      r = 1'b1;
      idle(2, 0);
      total++;
      if (dut_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL async_reset_release got=%h want=%h", dut_vec(), exp_vec());
      end
      $display("txn async_reset bcd=%h", sw_if.bcd);
   endtask

   task automatic test_random();
      bit ss, clr, ld, dn, lp;
      logic [15:0] lv;
      int errs;
      errs = 0;
      dn = 0;
      for (int i = 0; i < 3000; i++) begin
         clr = ($urandom_range(0, 99) == 0);
         ld  = ($urandom_range(0, 19) == 0);
         ss  = ($urandom_range(0, 23) == 0);
         lp  = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 15) == 0) dn = ~dn;
         case ($urandom_range(0, 3))
            0:       lv = 16'($urandom);
            1:       lv = {4'(MTM), 4'h9, 4'h5, 4'($urandom_range(5, 9))};
            2:       lv = {12'h000, 4'($urandom_range(0, 4))};
            default: lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
         endcase
         drive(ss, clr, ld, lv, dn, lp);
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            errs++;
            if (errs <= 10)
               $display("FAIL random_cycle_%0d got=%h want=%h", i, dut_vec(), exp_vec());
         end
      end
      $display("txn random cycles=3000 errors=%0d", errs);
   endtask

   initial begin
      sw_if.start_stop = 1'b0;
      sw_if.clear      = 1'b0;
      sw_if.load       = 1'b0;
      sw_if.load_val   = 16'h0000;
      sw_if.down       = 1'b0;
      sw_if.lap        = 1'b0;
      model_reset();
      test_reset();
      test_count_up();
      test_wrap();
      test_count_down();
      test_pause();
      test_saturation();
      test_lap();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Parametrised BCD stopwatch/timer core: the next-generation counting engine behind the MM:SS seven-segment display path. It replaces the fixed ripple-clocked 0–9/0–5 digit chain with a fully synchronous design: single clock, integrated tick prescaler, start/stop/clear/preset control, a count-down timer mode with expiry, and an optional lap-freeze register. Its outputs feed the existing four-digit hex display multiplexer unchanged.

## Interface
Parameters:
- TICK_DIV, 100_000_000, clk cycles per count step (1 s at 100 MHz); legal ≥ 2
- MIN_TENS_MAX, 5, maximum minutes-tens digit (5 → 59:59, 9 → 99:59); legal 1..9

Ports:
- clk  in  1  system clock, all logic on rising edge
- r  in  1  reset, asynchronous, active-low
- start_stop  in  1  single-cycle pulse; toggles run/pause
- clear  in  1  single-cycle pulse; zero count, go IDLE
- load  in  1  single-cycle pulse; preset count from load_val
- load_val  in  16  preset {min_tens, min_units, sec_tens, sec_units}, BCD
- down  in  1  mode: 0 count up, 1 count down
- lap  in  1  single-cycle pulse; toggle lap freeze
- bcd  out  16  live count, same packing as load_val
- disp  out  16  value for display mux (live or frozen lap)
- running  out  1  high in RUN
- expired  out  1  count-down reached 00:00
- wrap  out  1  one-cycle pulse on count-up rollover
- lap_active  out  1  disp showing frozen lap value

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Reset → IDLE, all outputs 0.
- Command priority on one edge: clear > load > start_stop > lap.
- clear (any state): bcd=0, prescaler=0, lap released, expired=0 → IDLE.
- load: accepted in IDLE, PAUSE, EXPIRED; ignored in RUN. Digits above their maximum saturate (units → 9, sec_tens → 5, min_tens → MIN_TENS_MAX). Prescaler=0, expired=0 → IDLE.
- start_stop: IDLE/PAUSE → RUN; RUN → PAUSE; ignored in EXPIRED. From IDLE/PAUSE with down=1 and bcd=0: stay, no state change.
- down sampled on the edge entering RUN; changes during RUN ignored until next start.
- Prescaler: 0..TICK_DIV-1, advances only in RUN, holds in PAUSE (fraction preserved), zeroed by clear/load/reset.
- Step when prescaler==TICK_DIV-1 in RUN. Up: sec_units 9→0 carries to sec_tens 5→0 carries to min_units 9→0 carries to min_tens; at MIN_TENS_MAX:9:5:9 wraps to 00:00, wrap=1 for one cycle, stays RUN. Down: mirror borrow chain; step landing on 00:00 → EXPIRED, running=0, expired=1 held until clear/load.
- Lap pulse in RUN or PAUSE: if not lap_active, capture bcd into lap register, lap_active=1; else release, lap_active=0. disp = lap_active ? lap register : bcd.

## Timing
- All outputs registered; change one edge after the causing input/tick.
- First step occurs TICK_DIV cycles after the start_stop edge from IDLE; bcd updates on that edge.
- running asserts the edge start_stop is sampled.
- lap coincident with a step captures the pre-step value.
- Reset mid-operation: immediate asynchronous return to reset values; deassertion synchronous in effect at next edge.

## Configuration
- STOPWATCH_LAP_EN defined: lap register and lap logic present as above.
- Undefined: lap input ignored, no lap register, disp=bcd combinationally equal, lap_active tied 0.

## Test plan
- TICK_DIV=4, up: reset, start → bcd=0x0001 after 4 cycles, 0x0010 after 40 cycles; running=1.
- load 0x5958, start, up, MIN_TENS_MAX=5 → 0x5959 then 0x0000 with wrap high exactly one cycle.
- load 0x0002, start, down → 0x0001, 0x0000, expired=1, running=0; start_stop ignored until clear.
- Run 2 cycles of prescaler, pause 10 cycles, resume → next step after remaining 2 cycles; load during RUN ignored.
- load 0xAF7C → bcd=0x5959 (saturation); clear+load same edge → bcd=0x0000.
- With STOPWATCH_LAP_EN: lap at bcd=0x0003 → disp holds 0x0003 while bcd advances; second lap → disp=bcd; without macro disp always = bcd.
